// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Fetch FSM state encoding and the default acknowledge timeout.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } if_state_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int DEFAULT_ADDR_W  = 32;
  localparam int DEFAULT_DATA_W  = 32;

endpackage

// File: rtl/if_hold_buf.sv
// Word+address holding register for a fetched instruction
// that arrives while decode is stalled on the previous one.
module if_hold_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] word_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] word_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      word_o  <= '0;
      addr_o  <= '0;
      valid_o <= 1'b0;
    end else if (clear) begin
      word_o  <= '0;
      addr_o  <= '0;
      valid_o <= 1'b0;
    end else if (load) begin
      word_o  <= word_i;
      addr_o  <= addr_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC sample, imem req/ack fetch,
// IF/ID output slot with stall hold buffer, flush and timeout.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_write_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  output logic              fault_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  if_state_e state_q, state_d;

  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] ipc_d;
  logic              valid_d;
  logic              pcw_d;
  logic              fault_d;
  logic              fpend_q, fpend_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              buf_load, buf_clear;
  logic [DATA_W-1:0] buf_word;
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_valid;

  logic slot_free;
  logic drop;
  logic tmo_hit;
  logic can_sample;

  assign slot_free = !instr_valid_o || !stall_i;
  assign drop      = fpend_q || flush_i;
  assign tmo_hit   = (cnt_q >= TMAX);
  // Hold off while the PC is still taking the last pc_write pulse,
  // otherwise the old PC would be fetched a second time.
  assign can_sample = !flush_i && !pc_write_o;

  if_hold_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_hold (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .load   (buf_load),
    .clear  (buf_clear),
    .word_i (imem_data_i),
    .addr_i (imem_addr_o),
    .word_o (buf_word),
    .addr_o (buf_addr),
    .valid_o(buf_valid)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_sample) state_d = WAIT;
      end
      WAIT: begin
        if (imem_ack_i) begin
          if (drop || slot_free) state_d = IDLE;
          else state_d = HOLD;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (flush_i || !stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d     = imem_req_o;
    addr_d    = imem_addr_o;
    instr_d   = instr_o;
    ipc_d     = instr_pc_o;
    valid_d   = instr_valid_o;
    pcw_d     = 1'b0;
    fault_d   = fault_o;
    fpend_d   = fpend_q;
    cnt_d     = cnt_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;

    // Slot drains when decode takes it or a branch kills it.
    if (flush_i || !stall_i) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (can_sample) begin
          req_d  = 1'b1;
          addr_d = pc_i;
          cnt_d  = '0;
        end
      end
      WAIT: begin
        if (flush_i) fpend_d = 1'b1;
        if (imem_ack_i) begin
          req_d   = 1'b0;
          fpend_d = 1'b0;
          if (!drop) begin
            if (slot_free) begin
              instr_d = imem_data_i;
              ipc_d   = imem_addr_o;
              valid_d = 1'b1;
              pcw_d   = 1'b1;
            end else begin
              buf_load = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          fpend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (flush_i) begin
          buf_clear = 1'b1;
        end else if (!stall_i) begin
          instr_d   = buf_word;
          ipc_d     = buf_addr;
          valid_d   = buf_valid;
          pcw_d     = 1'b1;
          buf_clear = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_o    <= 1'b0;
      imem_addr_o   <= '0;
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
      pc_write_o    <= 1'b0;
      fault_o       <= 1'b0;
      fpend_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      imem_req_o    <= req_d;
      imem_addr_o   <= addr_d;
      instr_o       <= instr_d;
      instr_pc_o    <= ipc_d;
      instr_valid_o <= valid_d;
      pc_write_o    <= pcw_d;
      fault_o       <= fault_d;
      fpend_q       <= fpend_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule
